// File: rtl/fifo_rr_drain_sched.sv
// Round-robin drain scheduler: pops one of NUM_PORTS registered-read FIFOs at a time,
// with a burst limit, and presents each beat on a valid/ready port tagged with its source.
//
// state | meaning
// ARB   | pick the next requesting port after r_last (wrapping)
// RD    | pop strobe toward the granted FIFO if it still holds data
// LOAD  | FIFO read data valid; capture beat and source index
// HOLD  | beat presented; wait for out_ready, then continue burst or release
module fifo_rr_drain_sched #(
    parameter  int NUM_PORTS  = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int BURST_MAX  = 4,
    localparam int PW         = $clog2(NUM_PORTS)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_PORTS-1:0]            i_port_en,
    input  logic [NUM_PORTS-1:0]            i_fifo_empty,
    output logic [NUM_PORTS-1:0]            o_fifo_rd_en,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_fifo_rd_data,
    output logic                            o_out_valid,
    input  logic                            i_out_ready,
    output logic [DATA_WIDTH-1:0]           o_out_data,
    output logic [PW-1:0]                   o_out_port,
    output logic                            o_busy
);

    localparam int            BW         = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        RD   = 2'd1,
        LOAD = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                r_state;
    logic [PW-1:0]         r_grant;
    logic [PW-1:0]         r_last;
    logic [BW-1:0]         r_burst_cnt;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [PW-1:0]         r_out_port;

    logic [NUM_PORTS-1:0]  w_req;
    logic [PW-1:0]         w_cand;
    logic [PW-1:0]         w_pick;
    logic                  w_found;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_continue;

    // Search starts one past the last served port so a steady requester waits at most NUM_PORTS-1 grants.
    always_comb begin
        w_req   = i_port_en & ~i_fifo_empty;
        w_cand  = '0;
        w_pick  = '0;
        w_found = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_cand = PW'((int'(r_last) + i) % NUM_PORTS);
            if (!w_found && w_req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_grant == PW'(i)) begin
                w_rd_data = i_fifo_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The FIFO empty flag already reflects the beat popped in RD by the time HOLD looks at it.
    assign w_continue = (r_burst_cnt < BURST_LAST) && !i_fifo_empty[r_grant] && i_port_en[r_grant];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ARB;
            r_grant     <= '0;
            r_last      <= PW'(NUM_PORTS - 1);
            r_burst_cnt <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_port  <= '0;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_found) begin
                        r_grant     <= w_pick;
                        r_burst_cnt <= '0;
                        r_state     <= RD;
                    end
                end
                RD: begin
                    if (i_fifo_empty[r_grant]) begin
                        r_last  <= r_grant;
                        r_state <= ARB;
                    end else begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_out_data  <= w_rd_data;
                    r_out_port  <= r_grant;
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_continue) begin
                            r_burst_cnt <= r_burst_cnt + 1'b1;
                            r_state     <= RD;
                        end else begin
                            r_last  <= r_grant;
                            r_state <= ARB;
                        end
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    always_comb begin
        o_fifo_rd_en = '0;
        if (r_state == RD && !i_fifo_empty[r_grant]) begin
            o_fifo_rd_en[r_grant] = 1'b1;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_port  = r_out_port;
    assign o_busy      = (r_state != ARB);

endmodule

// File: tb/tb_fifo_rr_drain_sched.sv
// Scoreboard bench for fifo_rr_drain_sched: behavioural registered-read FIFOs feed the DUT,
// directed stimulus queues hand-computed beats, a monitor pops and compares on each handshake.
module tb_fifo_rr_drain_sched;

    localparam int NP    = 4;
    localparam int DW    = 8;
    localparam int BM    = 4;
    localparam int PW    = 2;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    port_en;
    logic [NP-1:0]    fifo_empty;
    logic [NP-1:0]    fifo_rd_en;
    logic [NP*DW-1:0] fifo_rd_data;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [PW-1:0]    out_port;
    logic             busy;

    always #5 clk = ~clk;

    fifo_rr_drain_sched #(
        .NUM_PORTS (NP),
        .DATA_WIDTH(DW),
        .BURST_MAX (BM)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_port_en     (port_en),
        .i_fifo_empty  (fifo_empty),
        .o_fifo_rd_en  (fifo_rd_en),
        .i_fifo_rd_data(fifo_rd_data),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_data    (out_data),
        .o_out_port    (out_port),
        .o_busy        (busy)
    );

    // FIFO models: registered read, empty flag falls/rises on the popping edge
    logic [DW-1:0] mem    [NP][DEPTH];
    int            wr_ptr [NP] = '{default: 0};
    int            rd_ptr [NP] = '{default: 0};
    logic [DW-1:0] rd_q   [NP] = '{default: '0};

    always @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (fifo_rd_en[p] && wr_ptr[p] != rd_ptr[p]) begin
                rd_q[p]   <= mem[p][rd_ptr[p]];
                rd_ptr[p] <= rd_ptr[p] + 1;
            end
        end
    end

    always_comb begin
        fifo_empty   = '0;
        fifo_rd_data = '0;
        for (int p = 0; p < NP; p++) begin
            fifo_empty[p]            = (wr_ptr[p] == rd_ptr[p]);
            fifo_rd_data[p*DW +: DW] = rd_q[p];
        end
    end

    logic [PW+DW-1:0] exp_q [$];
    logic [PW+DW-1:0] exp_e;
    int               n_vec = 0;
    int               n_err = 0;
    int               cyc = 0;
    int               hs_cyc [$];
    int               proto_err = 0;
    bit               watch_p1 = 1'b0;
    bit               p1_seen = 1'b0;
    int               lat;
    int               bad;
    int               gexp [5] = '{3, 3, 3, 4, 3};
    int               fair_port [20] = '{2, 2, 2, 2, 3, 3, 3, 3, 0, 0, 0, 0, 1, 1, 1, 1, 2, 3, 0, 1};
    int               fair_beat [20] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 4, 4, 4, 4};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, req);
        end
    endtask

    task automatic push(input int p, input logic [DW-1:0] d);
        mem[p][wr_ptr[p]] = d;
        wr_ptr[p] = wr_ptr[p] + 1;
    endtask

    task automatic expect_beat(input int p, input logic [DW-1:0] d);
        exp_q.push_back({PW'(p), d});
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !out_valid) break;
        end
        check({name, "_remaining"}, exp_q.size(), 0);
        check({name, "_idle"}, busy, 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_rd_en != '0 && ($countones(fifo_rd_en) != 1 || (fifo_rd_en & fifo_empty) != '0))
            proto_err++;
        if (watch_p1 && fifo_rd_en[1]) p1_seen = 1'b1;
        if (!rst && out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got port %0d data 'h%0h, expected no beat", out_port, out_data);
            end else begin
                exp_e = exp_q.pop_front();
                check("beat", {out_port, out_data}, exp_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        port_en   = '1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_data", out_data, 0);
        check("rst_port", out_port, 0);

        // idle with every FIFO empty
        @(posedge clk); #1 rst = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid || fifo_rd_en != '0 || busy) bad++;
        end
        check("idle_quiet", bad, 0);

        // first beat after reset release: valid on the third edge
        @(posedge clk); #1 rst = 1'b1;
        push(0, 8'hA5);
        expect_beat(0, 8'hA5);
        @(posedge clk); #1 rst = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check("first_latency", lat, 3);
        check("first_data", out_data, 8'hA5);
        check("first_port", out_port, 0);
        wait_drain("first", 40);

        // burst limit: 6 beats on port 1, burst of 4 then re-arbitration
        @(posedge clk); #1;
        hs_cyc.delete();
        for (int i = 0; i < 6; i++) begin
            push(1, 8'(8'h10 + i));
            expect_beat(1, 8'(8'h10 + i));
        end
        wait_drain("burst", 100);
        check("burst_count", hs_cyc.size(), 6);
        if (hs_cyc.size() == 6) begin
            for (int i = 0; i < 5; i++) check("burst_gap", hs_cyc[i+1] - hs_cyc[i], gexp[i]);
        end

        // fairness: 5 beats per port, last served was port 1
        @(posedge clk); #1;
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 5; k++) push(p, 8'(p * 16 + k));
        for (int i = 0; i < 20; i++) expect_beat(fair_port[i], 8'(fair_port[i] * 16 + fair_beat[i]));
        wait_drain("fair", 300);

        // backpressure
        @(posedge clk); #1;
        out_ready = 1'b0;
        push(0, 8'h77);
        expect_beat(0, 8'h77);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("bp_valid", out_valid, 1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || out_data != 8'h77 || out_port != 2'd0 || fifo_rd_en != '0) bad++;
        end
        check("bp_stable", bad, 0);
        @(posedge clk); #1;
        push(0, 8'h78);
        expect_beat(0, 8'h78);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("bp_next_data", out_data, 8'h78);
        check("bp_one_accepted", exp_q.size(), 1);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain("bp", 40);

        // masking: port 1 masked; port 2 released mid-burst
        @(posedge clk); #1;
        port_en   = 4'b1101;
        out_ready = 1'b0;
        watch_p1  = 1'b1;
        push(1, 8'h5A);
        push(2, 8'hC0);
        push(2, 8'hC1);
        push(2, 8'hC2);
        push(3, 8'hD0);
        expect_beat(2, 8'hC0);
        expect_beat(3, 8'hD0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("mask_first_port", out_port, 2);
        @(posedge clk); #1;
        port_en   = 4'b1001;
        out_ready = 1'b1;
        wait_drain("mask", 60);
        repeat (5) @(negedge clk);
        check("mask_stays_idle", busy, 0);
        check("mask_port1_never", p1_seen, 0);
        watch_p1 = 1'b0;

        // reset in LOAD drops the popped beat; first grant afterwards is lowest requester
        @(posedge clk); #1 port_en = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fifo_rd_en != '0) break;
        end
        check("rd_en_port1", fifo_rd_en, 4'b0010);
        @(posedge clk); #1;
        rst = 1'b1;
        push(3, 8'hE0);
        @(negedge clk);
        check("midrst_valid", out_valid, 0);
        check("midrst_rd_en", fifo_rd_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_data", out_data, 0);
        check("midrst_port", out_port, 0);
        expect_beat(2, 8'hC1);
        expect_beat(2, 8'hC2);
        expect_beat(3, 8'hE0);
        @(posedge clk); #1 rst = 1'b0;
        wait_drain("post_rst", 80);

        check("protocol", proto_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
